// File: rtl/ppu_status_reg.sv
// ppu_status_reg
//   Parametrised PPU status register. It holds NFLAGS sticky status flags, each
//   with its own set and clear events. Selected flags clear when the CPU reads
//   the register. It also produces the NMI level and the NMI edge pulse from
//   the VBLANK flag (the MSB flag) and the PPUCTRL NMI enable.
//
// Ports
//   Clk           system clock
//   Reset         asynchronous, active-high reset
//   Load          parallel load of flags from Data_In[WIDTH-1 -: NFLAGS]
//   Data_In       load data
//   Set           per-flag set strobe
//   Clr           per-flag clear strobe
//   Read          CPU read strobe, one cycle per access
//   OpenBus       stale PPU bus value returned in the unused low bits
//   NMI_En        PPUCTRL NMI enable
//   Flags         live flag state
//   Data_Out      captured read data, held until the next Read
//   Rd_Valid      Data_Out valid strobe
//   Toggle_Reset  one-cycle pulse that clears the PPU w latch
//   NMI_n         registered active-low NMI level
//   NMI_Pulse     one-cycle pulse on each NMI assertion
module ppu_status_reg #(
  parameter int                WIDTH     = 8,
  parameter int                NFLAGS    = 3,
  parameter logic [NFLAGS-1:0] RCLR_MASK = 3'b100
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    Load,
  input  logic [WIDTH-1:0]        Data_In,
  input  logic [NFLAGS-1:0]       Set,
  input  logic [NFLAGS-1:0]       Clr,
  input  logic                    Read,
  input  logic [WIDTH-NFLAGS-1:0] OpenBus,
  input  logic                    NMI_En,
  output logic [NFLAGS-1:0]       Flags,
  output logic [WIDTH-1:0]        Data_Out,
  output logic                    Rd_Valid,
  output logic                    Toggle_Reset,
  output logic                    NMI_n,
  output logic                    NMI_Pulse
);

  logic [NFLAGS-1:0] flags_reg;
  logic [NFLAGS-1:0] flags_next;
  logic [WIDTH-1:0]  data_out_reg;
  logic              rd_valid_reg;
  logic              toggle_reset_reg;
  logic              nmi_n_reg;
  logic              nmi_pulse_reg;
  logic              nmi_lvl;
  logic              nmi_lvl_q;

  // Per-flag next state. A read on a read-clear flag outranks its set strobe,
  // so a set landing in the same cycle as the read is lost (the VBLANK race
  // that suppresses NMI for that frame).
  genvar gi;
  generate
    for (gi = 0; gi < NFLAGS; gi++) begin : g_flag
      always_comb begin
        flags_next[gi] = flags_reg[gi];
        if (Load)
          flags_next[gi] = Data_In[WIDTH-NFLAGS+gi];
        else if (Clr[gi])
          flags_next[gi] = 1'b0;
        else if (Read && RCLR_MASK[gi])
          flags_next[gi] = 1'b0;
        else if (Set[gi])
          flags_next[gi] = 1'b1;
      end
    end
  endgenerate

  // NMI level comes from the registered VBLANK flag, so it trails the flag by
  // one cycle on NMI_n and NMI_Pulse.
  assign nmi_lvl = flags_reg[NFLAGS-1] & NMI_En;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      flags_reg        <= '0;
      data_out_reg     <= '0;
      rd_valid_reg     <= 1'b0;
      toggle_reset_reg <= 1'b0;
      nmi_n_reg        <= 1'b1;
      nmi_pulse_reg    <= 1'b0;
      nmi_lvl_q        <= 1'b0;
    end else begin
      flags_reg        <= flags_next;
      rd_valid_reg     <= Read;
      toggle_reset_reg <= Read;
      // Capture the flags as they were before this cycle's update.
      if (Read)
        data_out_reg <= {flags_reg, OpenBus};
      nmi_n_reg        <= ~nmi_lvl;
      nmi_lvl_q        <= nmi_lvl;
      nmi_pulse_reg    <= nmi_lvl & ~nmi_lvl_q;
    end
  end

  assign Flags        = flags_reg;
  assign Data_Out     = data_out_reg;
  assign Rd_Valid     = rd_valid_reg;
  assign Toggle_Reset = toggle_reset_reg;
  assign NMI_n        = nmi_n_reg;
  assign NMI_Pulse    = nmi_pulse_reg;

endmodule

// File: tb/tb_ppu_status_reg.sv
// tb_ppu_status_reg
//   Directed bench for ppu_status_reg with the default parameterisation.
//   Inputs change 1 time unit after the rising edge; outputs are checked
//   1 time unit after the rising edge.
module tb_ppu_status_reg;

  logic       Clk;
  logic       Reset;
  logic       Load;
  logic [7:0] Data_In;
  logic [2:0] Set;
  logic [2:0] Clr;
  logic       Read;
  logic [4:0] OpenBus;
  logic       NMI_En;
  logic [2:0] Flags;
  logic [7:0] Data_Out;
  logic       Rd_Valid;
  logic       Toggle_Reset;
  logic       NMI_n;
  logic       NMI_Pulse;

  int tests_run;
  int tests_failed;

  ppu_status_reg #(
    .WIDTH    (8),
    .NFLAGS   (3),
    .RCLR_MASK(3'b100)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Load        (Load),
    .Data_In     (Data_In),
    .Set         (Set),
    .Clr         (Clr),
    .Read        (Read),
    .OpenBus     (OpenBus),
    .NMI_En      (NMI_En),
    .Flags       (Flags),
    .Data_Out    (Data_Out),
    .Rd_Valid    (Rd_Valid),
    .Toggle_Reset(Toggle_Reset),
    .NMI_n       (NMI_n),
    .NMI_Pulse   (NMI_Pulse)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".flags"},    32'(Flags),        32'h0);
    check({tag, ".data_out"}, 32'(Data_Out),     32'h0);
    check({tag, ".rd_valid"}, 32'(Rd_Valid),     32'h0);
    check({tag, ".toggle"},   32'(Toggle_Reset), 32'h0);
    check({tag, ".nmi_n"},    32'(NMI_n),        32'h1);
    check({tag, ".pulse"},    32'(NMI_Pulse),    32'h0);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    Reset   = 1'b1;
    Load    = 1'b0;
    Data_In = 8'h00;
    Set     = 3'b000;
    Clr     = 3'b000;
    Read    = 1'b0;
    OpenBus = 5'h00;
    NMI_En  = 1'b0;

    tick();
    tick();
    check_reset_vals("por");
    Reset = 1'b0;
    tick();

    // Set VBLANK with NMI enabled, then read-clear it.
    NMI_En = 1'b1;
    Set    = 3'b100;
    tick();
    Set = 3'b000;
    check("set.flags_c1", 32'(Flags), 32'h4);
    check("set.nmi_n_c1", 32'(NMI_n), 32'h1);
    check("set.pulse_c1", 32'(NMI_Pulse), 32'h0);
    tick();
    check("set.nmi_n_c2", 32'(NMI_n), 32'h0);
    check("set.pulse_c2", 32'(NMI_Pulse), 32'h1);
    tick();
    check("set.pulse_c3", 32'(NMI_Pulse), 32'h0);
    check("set.nmi_n_c3", 32'(NMI_n), 32'h0);
    Read    = 1'b1;
    OpenBus = 5'h15;
    tick();
    Read = 1'b0;
    check("rd.data_out", 32'(Data_Out), 32'h95);
    check("rd.rd_valid", 32'(Rd_Valid), 32'h1);
    check("rd.toggle",   32'(Toggle_Reset), 32'h1);
    check("rd.flags",    32'(Flags), 32'h0);
    check("rd.nmi_n_r1", 32'(NMI_n), 32'h0);
    tick();
    check("rd.nmi_n_r2",    32'(NMI_n), 32'h1);
    check("rd.rd_valid_r2", 32'(Rd_Valid), 32'h0);
    check("rd.toggle_r2",   32'(Toggle_Reset), 32'h0);
    check("rd.data_hold",   32'(Data_Out), 32'h95);

    // VBLANK race: read and set together, set is lost.
    Read    = 1'b1;
    Set     = 3'b100;
    OpenBus = 5'h00;
    tick();
    Read = 1'b0;
    Set  = 3'b000;
    check("race.data_out", 32'(Data_Out), 32'h00);
    check("race.flags",    32'(Flags), 32'h0);
    for (int i = 0; i < 3; i++) begin
      check("race.nmi_n", 32'(NMI_n), 32'h1);
      check("race.pulse", 32'(NMI_Pulse), 32'h0);
      tick();
    end

    // Non-read-clear flag survives a read; Clr clears everything.
    Set = 3'b010;
    tick();
    Set = 3'b000;
    check("nrc.flags_set", 32'(Flags), 32'h2);
    Read    = 1'b1;
    OpenBus = 5'h03;
    tick();
    Read = 1'b0;
    check("nrc.data_out",   32'(Data_Out), 32'h43);
    check("nrc.flags_kept", 32'(Flags), 32'h2);
    Clr = 3'b111;
    tick();
    Clr = 3'b000;
    check("nrc.flags_clr", 32'(Flags), 32'h0);

    // Load outranks Clr. NMI disabled so VBLANK=1 raises no NMI yet.
    NMI_En  = 1'b0;
    Load    = 1'b1;
    Data_In = 8'hA0;
    Clr     = 3'b111;
    tick();
    Load = 1'b0;
    Clr  = 3'b000;
    check("load.flags", 32'(Flags), 32'h5);
    tick();
    check("load.nmi_n", 32'(NMI_n), 32'h1);
    check("load.pulse", 32'(NMI_Pulse), 32'h0);

    // NMI enable toggling while VBLANK=1.
    NMI_En = 1'b1;
    tick();
    check("en1.nmi_n", 32'(NMI_n), 32'h0);
    check("en1.pulse", 32'(NMI_Pulse), 32'h1);
    tick();
    check("en1.pulse_end", 32'(NMI_Pulse), 32'h0);
    NMI_En = 1'b0;
    tick();
    check("en0.nmi_n", 32'(NMI_n), 32'h1);
    check("en0.pulse", 32'(NMI_Pulse), 32'h0);
    NMI_En = 1'b1;
    tick();
    check("en2.nmi_n", 32'(NMI_n), 32'h0);
    check("en2.pulse", 32'(NMI_Pulse), 32'h1);

    // Back-to-back reads: second sees VBLANK already cleared.
    OpenBus = 5'h00;
    Read    = 1'b1;
    tick();
    check("b2b.data1",  32'(Data_Out), 32'hA0);
    check("b2b.valid1", 32'(Rd_Valid), 32'h1);
    tick();
    Read = 1'b0;
    check("b2b.data2",  32'(Data_Out), 32'h20);
    check("b2b.valid2", 32'(Rd_Valid), 32'h1);
    check("b2b.toggle2", 32'(Toggle_Reset), 32'h1);

    // Held Set re-sets VBLANK the cycle after a read clears it.
    Set = 3'b100;
    tick();
    check("hold.flags_set", 32'(Flags), 32'h5);
    Read = 1'b1;
    tick();
    Read = 1'b0;
    check("hold.flags_rd", 32'(Flags), 32'h1);
    check("hold.data",     32'(Data_Out), 32'hA0);
    tick();
    Set = 3'b000;
    check("hold.flags_reset", 32'(Flags), 32'h5);
    tick();
    tick();
    check("hold.nmi_n", 32'(NMI_n), 32'h0);

    // Asynchronous reset in the middle of a read.
    Read = 1'b1;
    tick();
    check("mid.rd_valid_pre", 32'(Rd_Valid), 32'h1);
    #2;
    Reset = 1'b1;
    #1;
    check_reset_vals("mid");
    Read = 1'b0;
    tick();
    Reset = 1'b0;
    tick();
    check("post.nmi_n", 32'(NMI_n), 32'h1);
    check("post.pulse", 32'(NMI_Pulse), 32'h0);
    check("post.rd_valid", 32'(Rd_Valid), 32'h0);
    tick();
    check("post.pulse2", 32'(NMI_Pulse), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
